sram_like_bridge: RTL

//  Converts one CPU memory port in stall-style SRAM form (en/wen/addr/wdata/rdata) into a

---
 rtl/sram_like_bridge_if.sv | 12 +
 rtl/sram_like_bridge.sv | 65 ++++++
 2 files changed

// File: rtl/sram_like_bridge_if.sv
// sram_like_bridge_if: sram-like request/response bus between a bridge and memory
interface sram_like_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic req, wr, addr_ok, data_ok;
  logic [1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_bridge.sv
// sram_like_bridge: stall-style CPU SRAM port to variable-latency sram-like handshake
module sram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit READ_ONLY = 1'b0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [1:0]          cpu_size,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_flush,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  sram_like_bridge_if.master  bus
);
  localparam int BE_W = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic drop, take, kill, wr_req, is_half;
  logic [1:0] wsize, size_nx;
  assign take = state == IDLE && cpu_en && !cpu_flush;
  // a flush arriving with the response still discards it
  assign kill = drop || cpu_flush;
  assign wr_req = !READ_ONLY && |cpu_wen;
  always_comb begin
    is_half = 1'b0;
    for (int i = 0; i < BE_W; i += 2) is_half = is_half | (cpu_wen == (BE_W'(3) << i));
  end
  assign wsize = $onehot(cpu_wen) ? 2'd0 : is_half ? 2'd1 : 2'd2;
  assign size_nx = READ_ONLY ? 2'd2 : wr_req ? wsize : cpu_size;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (take ? REQ : IDLE) :
               state == REQ  ? (bus.addr_ok ? WAIT : cpu_flush ? IDLE : REQ) :
               state == WAIT ? (bus.data_ok ? (kill ? IDLE : DONE) : WAIT) : IDLE;
  end
  always_comb begin
    bus.req = state == REQ;
    cpu_stall = resetn && (state == REQ || state == WAIT || take);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) drop <= 1'b0;
    else if (state == REQ && bus.addr_ok) drop <= cpu_flush;
    else if (state == WAIT) drop <= bus.data_ok ? 1'b0 : kill;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      bus.wr <= 1'b0;
      bus.size <= 2'd0;
      bus.addr <= '0;
      bus.wdata <= '0;
    end else if (take) begin
      bus.wr <= wr_req;
      bus.size <= size_nx;
      bus.addr <= cpu_addr;
      bus.wdata <= cpu_wdata;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cpu_rdata <= '0;
    else if (state == WAIT && bus.data_ok && !kill) cpu_rdata <= bus.rdata;
endmodule
